// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional bne decode is enabled with `define MIPS_MC_BNE_EN.
module mips_mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_RESET  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state;
    state_t     dec_next;
    logic       funct_ok;
    logic [2:0] funct_alu;

    // R-type funct decode; funct_ok also gates the EXEC transition
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b100110: funct_alu = 3'b011;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dec_next = S_FETCH;
        case (opcode)
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_RTYPE:     dec_next = funct_ok ? S_EXEC : S_FETCH;
            OP_BEQ:       dec_next = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       dec_next = S_BRANCH;
`endif
            OP_ADDI:      dec_next = S_ADDIEX;
            OP_J:         dec_next = S_JUMP;
            default:      dec_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: state <= dec_next;
                S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ADDIEX: state <= S_ADDIWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from state so an asynchronous reset clears them in the same cycle
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_RESET:  alu_control = 3'b000;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = (dec_next == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
`ifdef MIPS_MC_BNE_EN
                pc_write    = (opcode == OP_BNE) ? !zero : zero;
`else
                pc_write    = zero;
`endif
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = (state == S_RESET) ? 4'd0 : state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller against a per-instruction outcome model.
module tb_mips_mc_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    mips_mc_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    wire [20:0] outs = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                        alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, illegal_op, state_o};

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6, K_BNE = 7;
    localparam logic [5:0] RFUNCT [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    localparam logic [5:0] BADOP  [4] = '{6'b111111, 6'b000001, 6'b000011, 6'b100000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b100110: return 3;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return (alu_of(fn) >= 0) ? K_R : K_ILL;
            6'b001000: return K_ADDI;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
`ifdef MIPS_MC_BNE_EN
            6'b000101: return K_BNE;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    // Runs one instruction from FETCH with fw fetch waits and mw data-memory waits
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int fw, input int mw);
        int k, base, cyc, wf, wm;
        int n_ir, n_pcw, n_rw, n_mw, n_req, n_ill, viol;
        int rw_m2r, rw_dst, rw_alu, prev_alu, last_pcsrc;
        bit seen_ir, done, p_ir, p_pc, p_rw, mem_i, taken;
        string t;
        k = classify(op, fn);
        case (k)
            K_LW: base = 5;
            K_SW, K_R, K_ADDI: base = 4;
            K_ILL: base = 2;
            default: base = 3;
        endcase
        taken = (k == K_J) || (k == K_BEQ && z) || (k == K_BNE && !z);
        mem_i = (k == K_LW) || (k == K_SW);
        {cyc, n_ir, n_pcw, n_rw, n_mw, n_req, n_ill, viol} = '0;
        {rw_m2r, rw_dst, rw_alu, prev_alu, last_pcsrc} = '0;
        {seen_ir, done, p_ir, p_pc, p_rw} = '0;
        wf = fw; wm = mw;
        opcode = op; funct = fn; zero = z;
        while (!done && cyc < 40) begin
            @(negedge clk);
            #1;
            if (mem_req && !iord) begin
                if (wf > 0) begin mem_ready = 1'b0; wf--; end else mem_ready = 1'b1;
            end else if (mem_req) begin
                if (wm > 0) begin mem_ready = 1'b0; wm--; end else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if ((ir_write && p_ir) || (pc_write && p_pc) || (reg_write && p_rw)) viol++;
            {p_ir, p_pc, p_rw} = {ir_write, pc_write, reg_write};
            n_ir += int'(ir_write); n_pcw += int'(pc_write); n_rw += int'(reg_write);
            n_mw += int'(mem_write); n_req += int'(mem_req); n_ill += int'(illegal_op);
            if (reg_write) begin rw_m2r = int'(mem_to_reg); rw_dst = int'(reg_dst); rw_alu = prev_alu; end
            if (pc_write) last_pcsrc = int'(pc_src);
            prev_alu = int'(alu_control);
            if (ir_write) seen_ir = 1'b1;
            @(posedge clk);
            cyc++;
            #1;
            if (seen_ir && state_o == 4'd0) done = 1'b1;
        end
        t = $sformatf("op%b_fn%b", op, fn);
        chk({t, "_done"}, 32'(done), 32'd1);
        chk({t, "_cycles"}, cyc, base + fw + (mem_i ? mw : 0));
        chk({t, "_irw"}, n_ir, 1);
        chk({t, "_pcw"}, n_pcw, taken ? 2 : 1);
        chk({t, "_pcsrc"}, last_pcsrc, (k == K_J) ? 2 : (taken ? 1 : 0));
        chk({t, "_memreq"}, n_req, 1 + fw + (mem_i ? 1 + mw : 0));
        chk({t, "_memwr"}, n_mw, (k == K_SW) ? 1 + mw : 0);
        chk({t, "_illegal"}, n_ill, (k == K_ILL) ? 1 : 0);
        chk({t, "_consec"}, viol, 0);
        chk({t, "_regw"}, n_rw, (k == K_LW || k == K_R || k == K_ADDI) ? 1 : 0);
        if (n_rw == 1) begin
            chk({t, "_m2r"}, rw_m2r, (k == K_LW) ? 1 : 0);
            chk({t, "_dst"}, rw_dst, (k == K_R) ? 1 : 0);
            chk({t, "_alu"}, rw_alu, (k == K_R) ? alu_of(fn) : 2);
        end
    endtask

    initial begin
        int sel;
        logic [5:0] op, fn;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", 32'(outs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_hold_outs", 32'(outs), 32'd0);
        @(posedge clk);
        #1;
        chk("first_fetch_state", 32'(state_o), 32'd0);
        chk("first_fetch_req", 32'(mem_req), 32'd1);

        run_instr(6'b100011, 6'b000000, 1'b0, 2, 2);
        foreach (RFUNCT[i]) run_instr(6'b000000, RFUNCT[i], 1'b0, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b000001, 1'b0, 0, 0);
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 1, 3);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 8);
            fn = 6'($urandom);
            case (sel)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin op = 6'b000000; fn = RFUNCT[$urandom_range(0, 5)]; end
                3: begin op = 6'b000000; fn = 6'b000001; end
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                7: op = 6'b000101;
                default: op = BADOP[$urandom_range(0, 3)];
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset asserted while a store is waiting on memory
        opcode = 6'b101011; funct = 6'b000000;
        @(negedge clk); mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 chk("pre_reset_memwrite", 32'(mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("midwrite_reset_outs", 32'(outs), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_state", 32'(state_o), 32'd0);
        chk("post_reset_req", 32'(mem_req), 32'd1);
        chk("post_reset_nowrite", 32'(mem_write), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
